// File: rtl/miriscv_mem_arbiter.sv
// Two-requester arbiter (fetch/data) onto one memory port with an in-order owner tracking FIFO.
// Optional build macro MIRISCV_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: data over fetch).
module miriscv_mem_arbiter #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic              clk_i,
   input  logic              arstn_i,

   input  logic              instr_req_i,
   input  logic [XLEN-1:0]   instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic [XLEN-1:0]   instr_rdata_o,
   input  logic              instr_flush_i,

   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_gnt_o,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i
);

   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
   localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

   logic [CNT_W-1:0]       count_q, count_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OUTSTANDING-1:0] valid_q, valid_d;
   logic [OUTSTANDING-1:0] owner_data_q, owner_data_d;
   logic [OUTSTANDING-1:0] discard_q, discard_d;

   logic full;
   logic sel_data;
   logic accept;
   logic pop;
   logic head_data;
   logic head_discard;

   assign full = (count_q == CNT_W'(OUTSTANDING));

   // Winner selection: fixed data priority, or alternate on conflict when round-robin is built in
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
   logic rr_data_next_q, rr_data_next_d;

   assign sel_data       = data_req_i & (~instr_req_i | rr_data_next_q);
   assign rr_data_next_d = accept ? ~sel_data : rr_data_next_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) rr_data_next_q <= 1'b1;
      else          rr_data_next_q <= rr_data_next_d;
   end
`else
   assign sel_data = data_req_i;
`endif

   assign accept       = mem_req_o & mem_gnt_i;
   assign pop          = mem_rvalid_i & (count_q != '0);
   assign head_data    = owner_data_q[rd_ptr_q];
   assign head_discard = discard_q[rd_ptr_q];

   // Memory-side request mux; fields stay zero when nobody requests
   always_comb begin
      mem_req_o   = (instr_req_i | data_req_i) & ~full;
      mem_we_o    = sel_data & data_we_i;
      mem_be_o    = sel_data ? data_be_i : (instr_req_i ? {BE_W{1'b1}} : '0);
      mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
      mem_wdata_o = sel_data ? data_wdata_i : '0;
      instr_gnt_o = accept & ~sel_data;
      data_gnt_o  = accept & sel_data;
   end

   // Response routing; a head fetch popped during a flush is dropped too
   always_comb begin
      instr_rvalid_o = pop & ~head_data & ~head_discard & ~instr_flush_i;
      data_rvalid_o  = pop & head_data;
      instr_rdata_o  = mem_rdata_i;
      data_rdata_o   = mem_rdata_i;
   end

   // Tracking FIFO next state; flush marks only entries present before this cycle's push
   always_comb begin
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      valid_d      = valid_q;
      owner_data_d = owner_data_q;
      discard_d    = discard_q;

      if (instr_flush_i) begin
         for (int unsigned i = 0; i < OUTSTANDING; i++) begin
            if (valid_q[i] && !owner_data_q[i]) discard_d[i] = 1'b1;
         end
      end

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      if (accept) begin
         valid_d[wr_ptr_q]      = 1'b1;
         owner_data_d[wr_ptr_q] = sel_data;
         discard_d[wr_ptr_q]    = 1'b0;
         wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end

      case ({accept, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         valid_q      <= '0;
         owner_data_q <= '0;
         discard_q    <= '0;
      end else begin
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         valid_q      <= valid_d;
         owner_data_q <= owner_data_d;
         discard_q    <= discard_d;
      end
   end

   // A response with nothing outstanding is a protocol error; it is ignored by the logic above
   spurious_rvalid_a: assert property (@(posedge clk_i) disable iff (!arstn_i)
      !(mem_rvalid_i && (count_q == '0)))
      else $warning("miriscv_mem_arbiter: mem_rvalid_i with no outstanding transaction");

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter (default build): per-cycle vector table plus a memory-port scoreboard.
module tb_miriscv_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_flush_i;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   miriscv_mem_arbiter #(.XLEN(32), .OUTSTANDING(2)) dut (
      .clk_i(clk_i), .arstn_i(arstn_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_flush_i(instr_flush_i),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        flush;
      logic        e_req, e_ig, e_dg, e_irv, e_drv;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_txn_t;

   vec_t     vecs[$];
   mem_txn_t sb[$];
   int       n_pass = 0;
   int       n_total = 0;

   function automatic vec_t mk(input logic rst, input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe, input logic [31:0] daddr,
                               input logic gnt, input logic rv, input logic [31:0] rdata,
                               input logic flush, input logic e_req, input logic e_ig,
                               input logic e_dg, input logic e_irv, input logic e_drv);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
      v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.flush = flush;
      v.e_req = e_req; v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   initial begin
      mem_txn_t e;
      arstn_i = 1'b0;
      instr_req_i = 1'b0; instr_addr_i = '0; instr_flush_i = 1'b0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h3; data_addr_i = '0; data_wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      //        rst ireq iaddr       dreq dwe daddr       gnt rv rdata        fl  req ig dg irv drv
      // fetch only
      vecs.push_back(mk(0, 1, 32'h100, 0, 0, 32'h0,   1, 0, 32'h0,        0,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h00000013, 0,  0, 0, 0, 1, 0));
      // conflict: data wins three times, then fetch; responses D D D I
      vecs.push_back(mk(0, 1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h0,        0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h200, 1, 1, 32'h304, 1, 1, 32'hD0D0D0D0, 0,  1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 1, 32'h200, 1, 0, 32'h308, 1, 1, 32'hD1D1D1D1, 0,  1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h0,   1, 1, 32'hD2D2D2D2, 0,  1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h11111111, 0,  0, 0, 0, 1, 0));
      // full blocking and release one cycle after the pop
      vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'h400, 1, 0, 32'h0,        0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'h404, 1, 0, 32'h0,        0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h500, 1, 0, 32'h408, 1, 0, 32'h0,        0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'h408, 0, 1, 32'hAAAA0000, 0,  0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'h408, 1, 0, 32'h0,        0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hAAAA0001, 0,  0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hAAAA0002, 0,  0, 0, 0, 0, 1));
      // flush: head popped in flush cycle dropped, queued fetch dropped, data write answered
      vecs.push_back(mk(0, 1, 32'h600, 0, 0, 32'h0,   1, 0, 32'h0,        0,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h604, 0, 0, 32'h0,   1, 0, 32'h0,        0,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hBBBB0000, 1,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h700, 1, 0, 32'h0,        0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hBBBB0001, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hBBBB0002, 0,  0, 0, 0, 0, 1));
      // fetch pushed in a flush cycle is kept
      vecs.push_back(mk(0, 1, 32'h800, 0, 0, 32'h0,   1, 0, 32'h0,        1,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hCCCC0000, 0,  0, 0, 0, 1, 0));
      // reset mid-operation: later responses are spurious and the count restarts at 0
      vecs.push_back(mk(0, 1, 32'h900, 0, 0, 32'h0,   1, 0, 32'h0,        0,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'hA00, 1, 0, 32'h0,        0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h904, 0, 0, 32'h0,   0, 1, 32'hEEEE0000, 0,  1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hEEEE0001, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h908, 0, 0, 32'h0,   1, 0, 32'h0,        0,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h90C, 0, 0, 32'h0,   1, 0, 32'h0,        0,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h910, 0, 0, 32'h0,   1, 0, 32'h0,        0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hFFFF0000, 0,  0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hFFFF0001, 0,  0, 0, 0, 1, 0));

      // reset state with all inputs low
      data_be_i = 4'h0;
      repeat (2) @(negedge clk_i);
      #2;
      chk("rst mem_req",   32'(mem_req_o), 32'h0);
      chk("rst mem_be",    32'(mem_be_o), 32'h0);
      chk("rst mem_addr",  mem_addr_o, 32'h0);
      chk("rst gnt",       32'({instr_gnt_o, data_gnt_o}), 32'h0);
      chk("rst rvalid",    32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
      arstn_i = 1'b1;
      data_be_i = 4'h3;

      foreach (vecs[k]) begin
         vec_t v;
         v = vecs[k];
         @(negedge clk_i);
         instr_req_i = v.ireq; instr_addr_i = v.iaddr; instr_flush_i = v.flush;
         data_req_i = v.dreq; data_we_i = v.dwe; data_addr_i = v.daddr; data_wdata_i = ~v.daddr;
         mem_gnt_i = v.gnt; mem_rvalid_i = v.rv; mem_rdata_i = v.rdata;
         if (v.rst) begin
            arstn_i = 1'b0;
            #1 arstn_i = 1'b1;
         end
         if (v.e_ig) begin
            e.addr = v.iaddr; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0;
            sb.push_back(e);
         end
         if (v.e_dg) begin
            e.addr = v.daddr; e.we = v.dwe; e.be = 4'h3; e.wdata = ~v.daddr;
            sb.push_back(e);
         end
         #2;
         chk($sformatf("v%0d mem_req", k),      32'(mem_req_o), 32'(v.e_req));
         chk($sformatf("v%0d instr_gnt", k),    32'(instr_gnt_o), 32'(v.e_ig));
         chk($sformatf("v%0d data_gnt", k),     32'(data_gnt_o), 32'(v.e_dg));
         chk($sformatf("v%0d instr_rvalid", k), 32'(instr_rvalid_o), 32'(v.e_irv));
         chk($sformatf("v%0d data_rvalid", k),  32'(data_rvalid_o), 32'(v.e_drv));
         if (v.e_irv) chk($sformatf("v%0d instr_rdata", k), instr_rdata_o, v.rdata);
         if (v.e_drv) chk($sformatf("v%0d data_rdata", k),  data_rdata_o, v.rdata);
         if (mem_req_o && mem_gnt_i) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d unexpected accept", k), 32'(sb.size()), 32'h1);
            end else begin
               e = sb.pop_front();
               chk($sformatf("v%0d mem_addr", k),  mem_addr_o, e.addr);
               chk($sformatf("v%0d mem_we", k),    32'(mem_we_o), 32'(e.we));
               chk($sformatf("v%0d mem_be", k),    32'(mem_be_o), 32'(e.be));
               chk($sformatf("v%0d mem_wdata", k), mem_wdata_o, e.wdata);
            end
         end
      end

      @(negedge clk_i);
      chk("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/miriscv_mem_arbiter.md
# miriscv_mem_arbiter

Two-requester arbiter sharing a single memory port between the instruction fetch path and the data (load/store) path of the miriscv core. It picks one requester per cycle, forwards the request to the memory, and records the owner of each accepted transaction in an in-order tracking FIFO. Each memory response is routed back to its owner, and instruction responses are discarded once a fetch flush has been issued. The block sits between the core's fetch/LSU ports and the single-ported system memory.

## Interface
- XLEN, 32, address/data width.
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions; power of two, at least 1.

- clk_i  in  1  clock.
- arstn_i  in  1  reset, asynchronous, active-low.
- instr_req_i / instr_addr_i  in  1 / XLEN  fetch request and word address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o / instr_rdata_o  out  1 / XLEN  fetch response.
- instr_flush_i  in  1  discard all outstanding fetch responses (driven by the pipeline force/redirect).
- data_req_i, data_we_i  in  1, 1  data request and write enable.
- data_be_i  in  XLEN/8  byte enables.
- data_addr_i, data_wdata_i  in  XLEN  data address and write data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o / data_rdata_o  out  1 / XLEN  data response; writes also receive an rvalid.
- mem_req_o, mem_we_o  out  1  memory request and write enable.
- mem_be_o  out  XLEN/8  byte enables; all ones for fetch.
- mem_addr_o, mem_wdata_o  out  XLEN  memory address and write data; wdata is 0 for fetch.
- mem_gnt_i  in  1  memory accepts the request.
- mem_rvalid_i / mem_rdata_i  in  1 / XLEN  memory response; in order, one per accepted request.

## Operation
- **Request.** mem_req_o = (instr_req_i | data_req_i) & ~full. Here full means count == OUTSTANDING, evaluated on the registered count.
- **Winner.** The selected requester's fields drive mem_*. Fixed priority: data wins over fetch (see Configuration).
- **Grant.** winner_gnt_o = mem_req_o & mem_gnt_i. The loser's gnt_o is 0.
- **Push.** Each accepted transaction pushes {owner, discard=0} into the tracking FIFO.
- **Pop.** mem_rvalid_i pops the FIFO head.
  - Owner = data: assert data_rvalid_o.
  - Owner = instr with discard=0: assert instr_rvalid_o.
  - Discarded entry: no rvalid on either output.
- **Read data.** instr_rdata_o = data_rdata_o = mem_rdata_i (broadcast). Only the rvalid outputs qualify it.
- **Flush.** instr_flush_i sets discard on every valid instr entry present at the start of the cycle.
  - A head instr entry popped in the flush cycle is suppressed as well.
  - An entry pushed in the flush cycle is not marked.
- **Spurious response.** mem_rvalid_i with an empty FIFO is a protocol error: ignored, no rvalid out, count unchanged, flagged by a simulation assertion.
- **Simultaneous push and pop.** Count is unchanged; the FIFO pointers still advance.

## Timing
- Request to mem_req_o and to gnt is combinational, 0 cycles.
- Response arrives at least 1 cycle after its grant. A response never pops an entry in the same cycle that entry is pushed.
- mem_rvalid_i to owner rvalid is combinational, 0 cycles.
- Full blocking uses the registered count. After a pop at full, mem_req_o can re-assert in the next cycle.
- **Reset values:**
  - Count 0, FIFO empty, all discard bits 0.
  - Round-robin pointer set to "data next".
  - With all inputs low, every output is 0.
- **Reset mid-operation:** outstanding entries are lost. Later mem_rvalid_i pulses are treated as spurious.

## Configuration
- **MIRISCV_ARB_ROUND_ROBIN_EN undefined:** fixed priority, data over fetch. Fetch can starve while data_req_i stays high.
- **MIRISCV_ARB_ROUND_ROBIN_EN defined:** a 1-bit last-winner register.
  - On conflict, the requester not granted last wins.
  - The register updates only on an accepted transaction.
  - After reset, data wins the first conflict.
  - With no conflict, the sole requester wins.

## Test plan
- **Fetch only:** instr_req_i=1, addr 0x100, mem_gnt_i=1; mem_rvalid_i=1 next cycle with rdata 0x00000013 -> mem_addr_o=0x100, mem_be_o=0xF, instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 with 0x00000013 in cycle 1, data_rvalid_o=0.
- **Conflict, default build:** both request for 3 cycles, data then drops -> data_gnt_o=1 for 3 cycles, instr_gnt_o=1 in cycle 3; responses routed D, D, D, I in order.
- **Conflict, MIRISCV_ARB_ROUND_ROBIN_EN build:** both request for 4 cycles with mem_gnt_i=1 -> grant order D, I, D, I.
- **Full:** OUTSTANDING=2, two accepts with no response -> cycle 2: mem_req_o=0 and both gnt 0; rvalid in cycle 3 -> mem_req_o=1 in cycle 4.
- **Flush:** two fetches outstanding, then one data write accepted; instr_flush_i pulsed; three rvalids follow -> instr_rvalid_o stays 0, data_rvalid_o=1 only on the third.
- **Reset mid-operation:** two outstanding, arstn_i pulsed low, then mem_rvalid_i=1 -> no rvalid on either output, count stays 0, mem_req_o follows the requests.
